// File: rtl/fetch_unit.sv
// fetch_unit: boot-vector load then 1/2-word instruction fetch into registered IF/ID outputs
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR_ADDR = 32'h0000_0000,
  parameter int unsigned IMM_FLAG_BIT = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic [15:0] i_imem_data,
  output logic [31:0] o_imem_address,
  output logic        o_imem_enable,
  output logic [15:0] o_instruction,
  output logic [15:0] o_immediate,
  output logic [31:0] o_pc,
  output logic [31:0] o_next_pc,
  output logic        o_valid
);
  typedef enum logic [1:0] {BOOT_HI, BOOT_LO, FETCH, FETCH_IMM} state_t;
  state_t      state_q;
  logic [31:0] pc_q, opc_q, npc_q, pc_inc1, pc_inc2;
  logic [15:0] hold_q, instr_q, imm_q;
  logic        valid_q;
  logic        boot;
  assign pc_inc1 = pc_q + 32'd1;
  assign pc_inc2 = pc_q + 32'd2;
  assign boot = (state_q == BOOT_HI) || (state_q == BOOT_LO);
  always_comb begin
    o_imem_address = state_q == BOOT_HI ? RESET_VECTOR_ADDR :
                     state_q == BOOT_LO ? RESET_VECTOR_ADDR + 32'd1 :
                     state_q == FETCH   ? pc_q : pc_inc1;
    o_imem_enable  = boot | ~i_stall;
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= BOOT_HI;
      pc_q    <= '0;
      hold_q  <= '0;
      instr_q <= '0;
      imm_q   <= '0;
      opc_q   <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT_HI: begin
          pc_q[31:16] <= i_imem_data;
          state_q     <= BOOT_LO;
        end
        BOOT_LO: begin
          pc_q[15:0] <= i_imem_data;
          state_q    <= FETCH;
        end
        default: begin
          if (i_branch_taken) begin
            pc_q    <= i_branch_target;
            state_q <= FETCH;
            hold_q  <= '0;
            valid_q <= 1'b0;
          end else if (!i_stall) begin
            if (state_q == FETCH_IMM) begin
              instr_q <= hold_q;
              imm_q   <= i_imem_data;
              opc_q   <= pc_q;
              npc_q   <= pc_inc2;
              valid_q <= 1'b1;
              pc_q    <= pc_inc2;
              state_q <= FETCH;
            end else if (i_imem_data[IMM_FLAG_BIT]) begin
              // first word of a 2-word instruction: park it and emit a bubble
              hold_q  <= i_imem_data;
              valid_q <= 1'b0;
              state_q <= FETCH_IMM;
            end else begin
              instr_q <= i_imem_data;
              imm_q   <= '0;
              opc_q   <= pc_q;
              npc_q   <= pc_inc1;
              valid_q <= 1'b1;
              pc_q    <= pc_inc1;
            end
          end
        end
      endcase
    end
  end
  assign o_instruction = instr_q;
  assign o_immediate   = imm_q;
  assign o_pc          = opc_q;
  assign o_next_pc     = npc_q;
  assign o_valid       = valid_q;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR_ADDR, default 32'h0000_0000: word address of the 2-word boot vector {hi, lo}.
REQ-002 SHALL have parameter IMM_FLAG_BIT, default 15: instruction bit that marks a 2-word (immediate) instruction.
REQ-003 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 i_reset  in  1  asynchronous, active-high reset.
REQ-005 i_stall  in  1  hazard stall from decode/hazard unit.
REQ-006 i_branch_taken  in  1  redirect request; i_branch_target  in  32  redirect PC.
REQ-007 i_imem_data  in  16  word read from instruction memory, combinational (valid same cycle as address).
REQ-008 o_imem_address  out  32  word address to instruction memory; o_imem_enable  out  1  memory read enable.
REQ-009 o_instruction  out  16, o_immediate  out  16, o_pc  out  32, o_next_pc  out  32, o_valid  out  1: registered IF/ID outputs.

Function
REQ-010 SHALL implement states BOOT_HI, BOOT_LO, FETCH, FETCH_IMM; encoding free.
REQ-011 o_imem_address SHALL be combinational: BOOT_HI -> RESET_VECTOR_ADDR; BOOT_LO -> RESET_VECTOR_ADDR+1; FETCH -> pc; FETCH_IMM -> pc+1.
REQ-012 o_imem_enable SHALL be 1 in BOOT states and equal ~i_stall in FETCH/FETCH_IMM.
REQ-013 BOOT_HI: capture i_imem_data into pc[31:16]; go to BOOT_LO; i_stall and i_branch_taken ignored.
REQ-014 BOOT_LO: capture i_imem_data into pc[15:0]; go to FETCH; o_valid stays 0; stall/branch ignored.
REQ-015 FETCH, no stall/branch, i_imem_data[IMM_FLAG_BIT]=0: o_instruction<=word, o_immediate<=0, o_pc<=pc, o_next_pc<=pc+1, o_valid<=1, pc<=pc+1; stay FETCH.
REQ-016 FETCH, no stall/branch, flag=1: hold register<=word, o_valid<=0 (bubble), pc unchanged, go FETCH_IMM.
REQ-017 FETCH_IMM, no stall/branch: o_instruction<=hold, o_immediate<=i_imem_data, o_pc<=pc, o_next_pc<=pc+2, o_valid<=1, pc<=pc+2; go FETCH.
REQ-018 i_stall=1 (FETCH states, no branch): pc, state, hold register and all registered outputs SHALL hold.
REQ-019 i_branch_taken=1 in FETCH/FETCH_IMM SHALL take priority over i_stall: pc<=i_branch_target, state<=FETCH, hold discarded, o_valid<=0; other outputs hold.
REQ-020 PC arithmetic SHALL be modulo 2^32: pc+1 from 32'hFFFF_FFFF wraps to 0; pc+2 from 32'hFFFF_FFFF gives 1.
REQ-021 Latency: instruction at address A appears on outputs 1 cycle after A is presented (single-word) or 1 cycle after A+1 is presented (2-word).
REQ-022 Branch target is used as-is; no alignment or range check.

Reset
REQ-023 On i_reset=1, immediately and regardless of clock: state=BOOT_HI, pc=0, hold=0, o_instruction=0, o_immediate=0, o_pc=0, o_next_pc=0, o_valid=0.
REQ-024 Reset asserted mid-operation (including FETCH_IMM with held word) SHALL discard all state; boot sequence restarts on first edge after deassertion.

Verification
REQ-025 Boot: M[0]=16'h0000, M[1]=16'h0010, release reset -> address 0, then 1, then 32'h10; o_valid=0 for first two edges.
REQ-026 Single-word: M[10h]=1234h, M[11h]=2345h -> o_instruction 1234h/o_pc 10h/o_next_pc 11h, then 2345h/11h/12h, o_valid=1 both cycles.
REQ-027 Two-word: M[12h]=8001h, M[13h]=BEEFh -> one o_valid=0 cycle, then o_instruction 8001h, o_immediate BEEFh, o_pc 12h, o_next_pc 14h; next address 14h.
REQ-028 Stall in FETCH_IMM for 3 cycles -> state, pc=12h, outputs frozen, o_imem_enable=0; release -> REQ-027 result.
REQ-029 i_branch_taken=1 with i_stall=1, target 40h, while in FETCH_IMM -> next cycle address 40h, state FETCH, o_valid=0; held 8001h never emitted.
REQ-030 Async reset pulse between edges during FETCH -> outputs zero without a clock edge; boot from M[0..1] repeats.
